// File: rtl/fir_out_capture_if.sv
// fir_out_capture_if: stream and read-port bundle for fir_out_capture.
//   in_valid/in_sample : valid-only sample stream from the FIR (no backpressure)
//   rd_valid/rd_data   : first-word fall-through head of the capture FIFO
//   rd_ready           : reader pops when rd_valid & rd_ready
// Modports: master = producer/reader side, slave = fir_out_capture.
interface fir_out_capture_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_sample;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ready;

  modport master (
    output in_valid,
    output in_sample,
    output rd_ready,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  in_valid,
    input  in_sample,
    input  rd_ready,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/fir_out_capture.sv
// fir_out_capture: sink for the FIR output stream. After a start pulse it discards
// skip_count samples, then stores up to capture_count samples (0 = until stop) into
// an on-chip FIFO that a host reads back through a ready/valid port.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start, stop     : one-cycle arm / early-terminate pulses
//   skip_count      : samples to discard after arming (latched on start)
//   capture_count   : samples to capture, 0 = unlimited (latched on start)
//   bus             : fir_out_capture_if.slave (input stream + FIFO read port)
//   busy, done      : state is SKIP/CAPTURE, state is DONE
//   overflow        : sticky, a captured sample was dropped on a full FIFO
//   level           : FIFO occupancy, 0..DEPTH
//   captured        : samples observed in CAPTURE (stored or dropped)
//   peak            : maximum |sample| written during CAPTURE
//
// Optional feature: define FIR_CAPTURE_PEAK_EN to build the peak-magnitude tracker;
// otherwise peak is tied to zero.
module fir_out_capture #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned CNTBITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [CNTBITS-1:0]     skip_count,
  input  logic [CNTBITS-1:0]     capture_count,
  fir_out_capture_if.slave       bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNTBITS-1:0]     captured,
  output logic [WIDTH-1:0]       peak
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StSkip,
    StCapture,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [CNTBITS-1:0] skip_rem_q;
  logic [CNTBITS-1:0] cap_cnt_q;
  logic [CNTBITS-1:0] captured_q;
  logic [CNTBITS-1:0] captured_inc;
  logic               overflow_q;

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0]        wr_ptr_q;
  logic [AW:0]        rd_ptr_q;
  logic [AW:0]        fill;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               not_empty;
  logic               full;
  logic               pop;
  logic               arm;
  logic               skip_step;
  logic               capture_step;
  logic               wr_en;
  logic               drop;

  // ---------------------------------------------------------------------------
  // FIFO status
  // ---------------------------------------------------------------------------
  assign fill         = wr_ptr_q - rd_ptr_q;
  assign not_empty    = (fill != '0);
  assign full         = (fill == (AW + 1)'(DEPTH));
  assign pop          = not_empty & bus.rd_ready;
  assign captured_inc = captured_q + CNTBITS'(1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        // start beats a concurrent stop here because stop has no effect when idle.
        if (start) begin
          state_d = (skip_count != '0) ? StSkip : StCapture;
        end
      end
      StSkip: begin
        if (stop) begin
          state_d = StDone;
        end else if (bus.in_valid && (skip_rem_q == CNTBITS'(1))) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (stop) begin
          state_d = StDone;
        end else if (bus.in_valid && (cap_cnt_q != '0) && (captured_inc == cap_cnt_q)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    arm          = 1'b0;
    skip_step    = 1'b0;
    capture_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        arm = start;
      end
      StSkip: begin
        busy      = 1'b1;
        skip_step = bus.in_valid;
      end
      StCapture: begin
        busy         = 1'b1;
        capture_step = bus.in_valid;
      end
      StDone: begin
        done = 1'b1;
        arm  = start;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    // A same-cycle pop frees the slot, so a full FIFO can still take the sample.
    wr_en = capture_step & (~full | pop);
    drop  = capture_step & full & ~pop;
  end

  // ---------------------------------------------------------------------------
  // Counters, status and FIFO pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_rem_q <= '0;
      cap_cnt_q  <= '0;
      captured_q <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (arm) begin
        skip_rem_q <= skip_count;
        cap_cnt_q  <= capture_count;
        captured_q <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (skip_step) begin
          skip_rem_q <= skip_rem_q - CNTBITS'(1);
        end
        if (capture_step) begin
          captured_q <= captured_inc;
        end
        if (drop) begin
          overflow_q <= 1'b1;
        end
      end
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
      end
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= bus.in_sample;
    end
  end

  assign bus.rd_valid = not_empty;
  assign bus.rd_data  = not_empty ? mem[rd_ptr_q[AW-1:0]] : '0;
  assign level        = fill;
  assign captured     = captured_q;
  assign overflow     = overflow_q;

  // ---------------------------------------------------------------------------
  // Peak magnitude tracker
  // ---------------------------------------------------------------------------
`ifdef FIR_CAPTURE_PEAK_EN
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [WIDTH-1:0] MostPos = {1'b0, {(WIDTH - 1){1'b1}}};

  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] peak_q;

  // |most negative| does not fit in WIDTH bits, so it saturates.
  always_comb begin
    mag = bus.in_sample;
    if (bus.in_sample[WIDTH-1]) begin
      mag = (bus.in_sample == MostNeg) ? MostPos : (~bus.in_sample + WIDTH'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else if (arm) begin
      peak_q <= '0;
    end else if (wr_en && (mag > peak_q)) begin
      peak_q <= mag;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_fir_out_capture.sv
module tb_fir_out_capture;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNTBITS = 16;
  localparam int unsigned LW      = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic [CNTBITS-1:0] skip_count;
  logic [CNTBITS-1:0] capture_count;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [LW-1:0]      level;
  logic [CNTBITS-1:0] captured;
  logic [WIDTH-1:0]   peak;

  always #5 clk = ~clk;

  fir_out_capture_if #(.WIDTH(WIDTH)) bus ();

  fir_out_capture #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .CNTBITS(CNTBITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .skip_count   (skip_count),
    .capture_count(capture_count),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .level        (level),
    .captured     (captured),
    .peak         (peak)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [WIDTH-1:0] exp_peak(input logic [WIDTH-1:0] p);
`ifdef FIR_CAPTURE_PEAK_EN
    return p;
`else
    return '0;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: state name, remaining counts and a queue for the FIFO.
  // ---------------------------------------------------------------------------
  localparam int MIdle = 0, MSkip = 1, MCap = 2, MDone = 3;
  int                 m_state;
  int                 m_skip;
  int                 m_cap;
  logic [CNTBITS-1:0] m_captured;
  bit                 m_ovf;
  int                 m_peak;
  logic [WIDTH-1:0]   m_q[$];

  function automatic int magnitude(input logic [WIDTH-1:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > (2 ** (WIDTH - 1)) - 1) v = (2 ** (WIDTH - 1)) - 1;
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_state = MIdle;
    m_skip = 0;
    m_cap = 0;
    m_captured = '0;
    m_ovf = 0;
    m_peak = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input int sk, input int cp,
                            input bit v, input logic [WIDTH-1:0] s, input bit rr);
    int n;
    int nxt;
    bit pp;
    n = m_q.size();
    pp = rr && (n > 0);
    nxt = m_state;
    if (pp) void'(m_q.pop_front());
    case (m_state)
      MIdle, MDone: begin
        if (st) begin
          m_skip = sk;
          m_cap = cp;
          m_captured = '0;
          m_ovf = 0;
          m_peak = 0;
          nxt = (sk != 0) ? MSkip : MCap;
        end
      end
      MSkip: begin
        if (v) begin
          m_skip--;
          if (m_skip == 0) nxt = MCap;
        end
        if (sp) nxt = MDone;
      end
      MCap: begin
        if (v) begin
          m_captured++;
          if (n < int'(DEPTH) || pp) begin
            m_q.push_back(s);
            if (magnitude(s) > m_peak) m_peak = magnitude(s);
          end else begin
            m_ovf = 1;
          end
          if (m_cap != 0 && int'(m_captured) == m_cap) nxt = MDone;
        end
        if (sp) nxt = MDone;
      end
      default: nxt = MIdle;
    endcase
    m_state = nxt;
  endtask

  task automatic check_model(input string tag);
    check({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(m_q.size() != 0));
    check({tag, " rd_data"}, 32'(bus.rd_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    check({tag, " level"}, 32'(level), 32'(m_q.size()));
    check({tag, " busy"}, 32'(busy), 32'(m_state == MSkip || m_state == MCap));
    check({tag, " done"}, 32'(done), 32'(m_state == MDone));
    check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, " captured"}, 32'(captured), 32'(m_captured));
    check({tag, " peak"}, 32'(peak), 32'(exp_peak(WIDTH'(m_peak))));
  endtask

  // One clock: drive inputs just after an edge, advance the model, sample 1 after the edge.
  task automatic cycle(input bit st, input bit sp, input int sk, input int cp,
                       input bit v, input logic [WIDTH-1:0] s, input bit rr);
    start = st;
    stop = sp;
    skip_count = CNTBITS'(sk);
    capture_count = CNTBITS'(cp);
    bus.in_valid = v;
    bus.in_sample = s;
    bus.rd_ready = rr;
    model_step(st, sp, sk, cp, v, s, rr);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    bit st; bit sp; int sk; int cp; bit v; int s; bit rr;
    bit e_rv; int e_rd; int e_lvl; bit e_busy; bit e_done; bit e_ovf; int e_cap; int e_peak;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit st, input bit sp, input int sk, input int cp, input bit v,
                     input int s, input bit rr, input bit e_rv, input int e_rd,
                     input int e_lvl, input bit e_busy, input bit e_done, input bit e_ovf,
                     input int e_cap, input int e_peak);
    vec_t r;
    r = '{st, sp, sk, cp, v, s, rr, e_rv, e_rd, e_lvl, e_busy, e_done, e_ovf, e_cap, e_peak};
    vt.push_back(r);
  endtask

  initial begin
    logic [WIDTH-1:0] rs;
    rst = 1'b1;
    start = 0;
    stop = 0;
    skip_count = '0;
    capture_count = '0;
    bus.in_valid = 0;
    bus.in_sample = '0;
    bus.rd_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset rd_valid", 32'(bus.rd_valid), 0);
    check("reset rd_data", 32'(bus.rd_data), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset level", 32'(level), 0);
    check("reset captured", 32'(captured), 0);
    check("reset peak", 32'(peak), 0);
    rst = 1'b0;

    // skip=3 capture=4, samples 1..10, then drain.
    add(1,0,3,4,0,0,0, 0,0,0,1,0,0,0,0);
    add(0,0,0,0,1,1,0, 0,0,0,1,0,0,0,0);
    add(0,0,0,0,1,2,0, 0,0,0,1,0,0,0,0);
    add(0,0,0,0,1,3,0, 0,0,0,1,0,0,0,0);
    add(0,0,0,0,1,4,0, 1,4,1,1,0,0,1,4);
    add(0,0,0,0,1,5,0, 1,4,2,1,0,0,2,5);
    add(0,0,0,0,1,6,0, 1,4,3,1,0,0,3,6);
    add(0,0,0,0,1,7,0, 1,4,4,0,1,0,4,7);
    add(0,0,0,0,1,8,0, 1,4,4,0,1,0,4,7);
    add(0,0,0,0,1,9,0, 1,4,4,0,1,0,4,7);
    add(0,0,0,0,1,10,0, 1,4,4,0,1,0,4,7);
    add(0,0,0,0,0,0,1, 1,5,3,0,1,0,4,7);
    add(0,0,0,0,0,0,1, 1,6,2,0,1,0,4,7);
    add(0,0,0,0,0,0,1, 1,7,1,0,1,0,4,7);
    add(0,0,0,0,0,0,1, 0,0,0,0,1,0,4,7);
    // skip=0 capture=6 into a 4-deep FIFO with no reads: overflow.
    add(1,0,0,6,0,0,0, 0,0,0,1,0,0,0,0);
    add(0,0,0,0,1,1,0, 1,1,1,1,0,0,1,1);
    add(0,0,0,0,1,2,0, 1,1,2,1,0,0,2,2);
    add(0,0,0,0,1,3,0, 1,1,3,1,0,0,3,3);
    add(0,0,0,0,1,4,0, 1,1,4,1,0,0,4,4);
    add(0,0,0,0,1,5,0, 1,1,4,1,0,1,5,4);
    add(0,0,0,0,1,6,0, 1,1,4,0,1,1,6,4);
    // Unlimited capture; full FIFO with simultaneous pop and write; stop with a sample.
    add(1,0,0,0,0,0,0, 1,1,4,1,0,0,0,0);
    add(0,0,0,0,1,9,1, 1,2,4,1,0,0,1,9);
    add(0,1,0,0,1,10,1, 1,3,4,0,1,0,2,10);
    // Re-arm keeps FIFO data, clears captured; drain during SKIP; stop in SKIP.
    add(1,0,2,1,0,0,0, 1,3,4,1,0,0,0,0);
    add(0,0,0,0,0,0,1, 1,4,3,1,0,0,0,0);
    add(0,0,0,0,0,0,1, 1,9,2,1,0,0,0,0);
    add(0,0,0,0,0,0,1, 1,10,1,1,0,0,0,0);
    add(0,1,0,0,0,0,1, 0,0,0,0,1,0,0,0);
    // start+stop in DONE: start wins. start during CAPTURE is ignored.
    add(1,1,0,2,0,0,0, 0,0,0,1,0,0,0,0);
    add(1,0,5,9,1,51,0, 1,51,1,1,0,0,1,51);
    add(0,0,0,0,1,68,0, 1,51,2,0,1,0,2,68);
    add(0,1,0,0,0,0,1, 1,68,1,0,1,0,2,68);
    add(0,0,0,0,0,0,1, 0,0,0,0,1,0,2,68);

    foreach (vt[i]) begin
      cycle(vt[i].st, vt[i].sp, vt[i].sk, vt[i].cp, vt[i].v, WIDTH'(vt[i].s), vt[i].rr);
      check($sformatf("vec%0d rd_valid", i), 32'(bus.rd_valid), 32'(vt[i].e_rv));
      check($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(vt[i].e_rd));
      check($sformatf("vec%0d level", i), 32'(level), 32'(vt[i].e_lvl));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].e_busy));
      check($sformatf("vec%0d done", i), 32'(done), 32'(vt[i].e_done));
      check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vt[i].e_ovf));
      check($sformatf("vec%0d captured", i), 32'(captured), 32'(vt[i].e_cap));
      check($sformatf("vec%0d peak", i), 32'(peak), 32'(exp_peak(WIDTH'(vt[i].e_peak))));
    end

    // Peak saturation on the most negative sample.
    cycle(1, 0, 0, 3, 0, 16'h0000, 0);
    cycle(0, 0, 0, 0, 1, 16'h0100, 0);
    check("peak 0x0100", 32'(peak), 32'(exp_peak(16'h0100)));
    cycle(0, 0, 0, 0, 1, 16'h8000, 0);
    check("peak 0x8000", 32'(peak), 32'(exp_peak(16'h7FFF)));
    cycle(0, 0, 0, 0, 1, 16'hFF00, 0);
    check("peak 0xFF00", 32'(peak), 32'(exp_peak(16'h7FFF)));
    check("peak seq done", 32'(done), 1);
    check("peak seq head", 32'(bus.rd_data), 32'h0100);
    cycle(0, 0, 0, 0, 0, 16'h0000, 1);
    check("peak seq pop1", 32'(bus.rd_data), 32'h8000);
    cycle(0, 0, 0, 0, 0, 16'h0000, 1);
    check("peak seq pop2", 32'(bus.rd_data), 32'hFF00);
    cycle(0, 0, 0, 0, 0, 16'h0000, 1);
    check("peak seq empty", 32'(bus.rd_valid), 0);

    // Asynchronous reset in the middle of CAPTURE with three entries held.
    cycle(1, 0, 0, 0, 0, 16'h0000, 0);
    cycle(0, 0, 0, 0, 1, 16'h1234, 0);
    cycle(0, 0, 0, 0, 1, 16'hF234, 0);
    cycle(0, 0, 0, 0, 1, 16'h0042, 0);
    check("pre-rst level", 32'(level), 3);
    check("pre-rst busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst rd_valid", 32'(bus.rd_valid), 0);
    check("async rst rd_data", 32'(bus.rd_data), 0);
    check("async rst busy", 32'(busy), 0);
    check("async rst done", 32'(done), 0);
    check("async rst level", 32'(level), 0);
    check("async rst captured", 32'(captured), 0);
    check("async rst peak", 32'(peak), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Idle after reset: stop has no effect.
    cycle(0, 1, 0, 0, 1, 16'h0007, 1);
    check_model("post-rst idle");

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit st, sp, v, rr;
      int sk, cp;
      st = ($urandom_range(0, 29) == 0);
      sp = ($urandom_range(0, 49) == 0);
      sk = $urandom_range(0, 5);
      cp = $urandom_range(0, 8);
      v  = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 1) == 1);
      rs = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) rs = 16'h8000;
      cycle(st, sp, sk, cp, v, rs, rr);
      check_model($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
